// File: rtl/wireless_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wireless_pkg                                                         |
// | Shared state encoding and canned AT command ROM for wireless_cmd_tx. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package wireless_pkg;

    localparam int MAX_CMD_LEN = 8;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        TX_DATA   = 3'd1,
        SET_SETUP = 3'd2,
        TX_CMD    = 3'd3,
        SET_HOLD  = 3'd4,
        DONE      = 3'd5
    } state_t;

    function automatic logic [3:0] cmd_len(input logic [1:0] cmd);
        case (cmd)
            2'd0:    return 4'd2;
            2'd1:    return 4'd7;
            2'd2:    return 4'd8;
            default: return 4'd6;
        endcase
    endfunction

    // Strings are right-aligned in 64 bits, so character 0 sits in the highest used byte.
    function automatic logic [7:0] cmd_byte(input logic [1:0] cmd, input logic [3:0] idx);
        logic [8*MAX_CMD_LEN-1:0] w_str;
        int                       pos;
        case (cmd)
            2'd0:    w_str = {48'd0, "AT"};
            2'd1:    w_str = {8'd0, "AT+C001"};
            2'd2:    w_str = "AT+B9600";
            default: w_str = {16'd0, "AT+FU3"};
        endcase
        pos = int'(cmd_len(cmd)) - 1 - int'(idx);
        if (pos < 0) begin
            return 8'h00;
        end
        return w_str[pos*8 +: 8];
    endfunction

endpackage
`default_nettype wire

// File: rtl/wireless_cmd_tx_uart_tx_core.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_tx_core                                                         |
// | 8N1 serializer, DIV cycles per bit; restartable on its last cycle.   |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module uart_tx_core #(
    parameter int DIV = 10
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] byte_in,
    input  logic       start,
    output logic       line,
    output logic       busy,
    output logic       last_cycle
);

    localparam int                 c_CNT_W   = $clog2(DIV);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(DIV - 1);

    logic [c_CNT_W-1:0] r_cnt;
    logic [3:0]         r_idx;
    logic [9:0]         r_shift;
    logic               r_busy;
    logic               w_bit_end;

    assign w_bit_end  = (r_cnt == c_CNT_MAX);
    assign last_cycle = r_busy & w_bit_end & (r_idx == 4'd9);
    assign line       = r_busy ? r_shift[0] : 1'b1;
    assign busy       = r_busy;

    // A start on the final stop-bit cycle reloads directly, giving gapless frames.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_busy  <= 1'b0;
            r_cnt   <= '0;
            r_idx   <= 4'd0;
            r_shift <= '1;
        end else if (start) begin
            r_busy  <= 1'b1;
            r_cnt   <= '0;
            r_idx   <= 4'd0;
            r_shift <= {1'b1, byte_in, 1'b0};
        end else if (r_busy) begin
            if (w_bit_end) begin
                r_cnt <= '0;
                if (r_idx == 4'd9) begin
                    r_busy <= 1'b0;
                end else begin
                    r_idx   <= r_idx + 4'd1;
                    r_shift <= {1'b1, r_shift[9:1]};
                end
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/wireless_cmd_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | wireless_cmd_tx                                                      |
// | Drives the radio's serial input and set pin: raw bytes or AT config. |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module wireless_cmd_tx
    import wireless_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int BAUD         = 9600,
    parameter int SET_SETUP_MS = 40,
    parameter int SET_HOLD_MS  = 80
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cfg_start,
    input  logic [1:0] cfg_cmd,
    input  logic [7:0] data_in,
    input  logic       data_valid,
    output logic       data_ready,
    output logic       busy,
    output logic       cfg_done,
    output logic       wireless_rx,
    output logic       wireless_set
);

    localparam int c_DIV       = CLK_HZ / BAUD;
    localparam int c_SETUP_CYC = (CLK_HZ / 1000) * SET_SETUP_MS;
    localparam int c_HOLD_CYC  = (CLK_HZ / 1000) * SET_HOLD_MS;
    localparam int c_DLY_MAX   = (c_SETUP_CYC > c_HOLD_CYC) ? c_SETUP_CYC : c_HOLD_CYC;
    localparam int c_DLY_W     = $clog2(c_DLY_MAX + 1);

    localparam logic [c_DLY_W-1:0] c_SETUP_LOAD = c_DLY_W'(c_SETUP_CYC - 1);
    localparam logic [c_DLY_W-1:0] c_HOLD_LOAD  = c_DLY_W'(c_HOLD_CYC - 1);

    state_t             r_state, w_state_nxt;
    logic [1:0]         r_cmd, w_cmd_nxt;
    logic [3:0]         r_byte_idx, w_idx_nxt;
    logic [c_DLY_W-1:0] r_dly, w_dly_nxt;
    logic               w_core_start;
    logic [7:0]         w_core_byte;
    logic               w_core_line;
    logic               w_core_busy;
    logic               w_core_last;

    uart_tx_core #(
        .DIV (c_DIV)
    ) u_core (
        .clk        (clk),
        .rst_n      (rst_n),
        .byte_in    (w_core_byte),
        .start      (w_core_start),
        .line       (w_core_line),
        .busy       (w_core_busy),
        .last_cycle (w_core_last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state    <= IDLE;
            r_cmd      <= 2'd0;
            r_byte_idx <= 4'd0;
            r_dly      <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_cmd      <= w_cmd_nxt;
            r_byte_idx <= w_idx_nxt;
            r_dly      <= w_dly_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cmd_nxt    = r_cmd;
        w_idx_nxt    = r_byte_idx;
        w_dly_nxt    = r_dly;
        w_core_start = 1'b0;
        w_core_byte  = data_in;
        case (r_state)
            IDLE: begin
                if (cfg_start) begin
                    w_cmd_nxt   = cfg_cmd;
                    w_dly_nxt   = c_SETUP_LOAD;
                    w_state_nxt = SET_SETUP;
                end else if (data_valid) begin
                    w_core_start = 1'b1;
                    w_state_nxt  = TX_DATA;
                end
            end
            TX_DATA: begin
                if (w_core_last) begin
                    w_state_nxt = IDLE;
                end
            end
            SET_SETUP: begin
                if (r_dly == '0) begin
                    w_core_start = 1'b1;
                    w_core_byte  = cmd_byte(r_cmd, 4'd0);
                    w_idx_nxt    = 4'd0;
                    w_state_nxt  = TX_CMD;
                end else begin
                    w_dly_nxt = r_dly - 1'b1;
                end
            end
            TX_CMD: begin
                if (w_core_last) begin
                    if (r_byte_idx == cmd_len(r_cmd) - 4'd1) begin
                        w_dly_nxt   = c_HOLD_LOAD;
                        w_state_nxt = SET_HOLD;
                    end else begin
                        // Next byte is launched on the stop bit's last cycle to keep frames gapless.
                        w_core_start = 1'b1;
                        w_core_byte  = cmd_byte(r_cmd, r_byte_idx + 4'd1);
                        w_idx_nxt    = r_byte_idx + 4'd1;
                    end
                end
            end
            SET_HOLD: begin
                if (r_dly == '0) begin
                    w_state_nxt = DONE;
                end else begin
                    w_dly_nxt = r_dly - 1'b1;
                end
            end
            DONE: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign data_ready   = (r_state == IDLE) & ~cfg_start;
    assign busy         = (r_state != IDLE) | w_core_busy;
    assign cfg_done     = (r_state == DONE);
    assign wireless_rx  = w_core_line;
    assign wireless_set = ~((r_state == SET_SETUP) | (r_state == TX_CMD));

endmodule
`default_nettype wire

// File: tb/tb_wireless_cmd_tx.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_wireless_cmd_tx                                                   |
// | Self-checking bench: cycle-level schedule model plus latency table.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_wireless_cmd_tx;

    localparam int CLK_HZ       = 1000;
    localparam int BAUD         = 100;
    localparam int SET_SETUP_MS = 5;
    localparam int SET_HOLD_MS  = 3;
    localparam int DIV          = CLK_HZ / BAUD;
    localparam int SETUP_CYC    = (CLK_HZ / 1000) * SET_SETUP_MS;
    localparam int HOLD_CYC     = (CLK_HZ / 1000) * SET_HOLD_MS;
    localparam int N            = 40000;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       cfg_start;
    logic [1:0] cfg_cmd;
    logic [7:0] data_in;
    logic       data_valid;
    logic       data_ready;
    logic       busy;
    logic       cfg_done;
    logic       wireless_rx;
    logic       wireless_set;

    wireless_cmd_tx #(
        .CLK_HZ       (CLK_HZ),
        .BAUD         (BAUD),
        .SET_SETUP_MS (SET_SETUP_MS),
        .SET_HOLD_MS  (SET_HOLD_MS)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .cfg_start    (cfg_start),
        .cfg_cmd      (cfg_cmd),
        .data_in      (data_in),
        .data_valid   (data_valid),
        .data_ready   (data_ready),
        .busy         (busy),
        .cfg_done     (cfg_done),
        .wireless_rx  (wireless_rx),
        .wireless_set (wireless_set)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Expected per-cycle outputs, filled in whenever the model accepts a request.
    logic exp_rx   [N];
    logic exp_set  [N];
    logic exp_busy [N];
    logic exp_done [N];
    int   m_free_at;
    int   m_end;
    string cmds [4];

    int n_checks = 0;
    int n_errors = 0;

    int s_cyc;
    logic s_ready, s_done, s_busy, s_rx, s_set;

    typedef struct {
        bit       is_cfg;
        bit [1:0] cmd;
        bit [7:0] data;
        int       ready_lat;
        int       done_lat;
    } vec_t;
    vec_t vecs [6];

    task automatic chk(input string name, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0b want %0b", name, cyc, act, exp);
        end
    endtask

    task automatic chk_int(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    task automatic set_cycle(input int k, input logic rx, input logic st, input logic bz, input logic dn);
        if (k >= 0 && k < N) begin
            exp_rx[k]   = rx;
            exp_set[k]  = st;
            exp_busy[k] = bz;
            exp_done[k] = dn;
            if (k > m_end) m_end = k;
        end
    endtask

    task automatic clear_from(input int k);
        for (int i = k; i <= m_end && i < N; i++) begin
            exp_rx[i]   = 1'b1;
            exp_set[i]  = 1'b1;
            exp_busy[i] = 1'b0;
            exp_done[i] = 1'b0;
        end
    endtask

    // Frame bits: start 0, data LSB first, stop 1, each held DIV cycles.
    task automatic put_frame(input int first, input logic [7:0] b, input logic st);
        logic bitv;
        for (int j = 0; j < 10; j++) begin
            if (j == 0)      bitv = 1'b0;
            else if (j == 9) bitv = 1'b1;
            else             bitv = b[j-1];
            for (int c = 0; c < DIV; c++) set_cycle(first + j*DIV + c, bitv, st, 1'b1, 1'b0);
        end
    endtask

    task automatic sched_data(input int t, input logic [7:0] b);
        put_frame(t + 1, b, 1'b1);
        m_free_at = t + 1 + 10*DIV;
    endtask

    task automatic sched_cfg(input int t, input logic [1:0] c);
        string s;
        int    len, d;
        s   = cmds[c];
        len = s.len();
        for (int i = 1; i <= SETUP_CYC; i++) set_cycle(t + i, 1'b1, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < len; i++) put_frame(t + SETUP_CYC + 1 + i*10*DIV, s[i], 1'b0);
        d = t + SETUP_CYC + len*10*DIV + HOLD_CYC + 1;
        for (int i = d - HOLD_CYC; i < d; i++) set_cycle(i, 1'b1, 1'b1, 1'b1, 1'b0);
        set_cycle(d, 1'b1, 1'b1, 1'b1, 1'b1);
        m_free_at = d + 1;
    endtask

    // One clock cycle: check this cycle's outputs against the model, then let the model react.
    task automatic step();
        logic idle;
        #1;
        s_cyc   = cyc;
        s_ready = data_ready;
        s_done  = cfg_done;
        s_busy  = busy;
        s_rx    = wireless_rx;
        s_set   = wireless_set;
        if (cyc < N) begin
            chk("wireless_rx", wireless_rx, exp_rx[cyc]);
            chk("wireless_set", wireless_set, exp_set[cyc]);
            chk("busy", busy, exp_busy[cyc]);
            chk("cfg_done", cfg_done, exp_done[cyc]);
        end
        idle = (cyc >= m_free_at);
        chk("data_ready", data_ready, idle & ~cfg_start);
        if (!rst_n) begin
            clear_from(cyc + 1);
            m_free_at = cyc + 1;
        end else if (idle) begin
            if (cfg_start)       sched_cfg(cyc, cfg_cmd);
            else if (data_valid) sched_data(cyc, data_in);
        end
        @(negedge clk);
    endtask

    task automatic run_to_idle(output int rdy_c, output int done_c, output int ndone);
        rdy_c  = -1;
        done_c = -1;
        ndone  = 0;
        for (int i = 0; i < 2000; i++) begin
            step();
            if (s_done) begin
                ndone++;
                done_c = s_cyc;
            end
            if (s_ready) begin
                rdy_c = s_cyc;
                break;
            end
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int t0, rdy_c, done_c, ndone, t_rst;
        cmds[0] = "AT";
        cmds[1] = "AT+C001";
        cmds[2] = "AT+B9600";
        cmds[3] = "AT+FU3";
        for (int i = 0; i < N; i++) begin
            exp_rx[i]   = 1'b1;
            exp_set[i]  = 1'b1;
            exp_busy[i] = 1'b0;
            exp_done[i] = 1'b0;
        end
        m_end = 0;
        vecs[0] = '{1'b0, 2'd0, 8'hA5, 101, -1};
        vecs[1] = '{1'b1, 2'd0, 8'h00, 210, 209};
        vecs[2] = '{1'b1, 2'd2, 8'h00, 810, 809};
        vecs[3] = '{1'b0, 2'd0, 8'h3C, 101, -1};
        vecs[4] = '{1'b1, 2'd1, 8'h00, 710, 709};
        vecs[5] = '{1'b1, 2'd3, 8'h00, 610, 609};

        rst_n = 1'b0; cfg_start = 1'b0; cfg_cmd = 2'd0; data_in = 8'h00; data_valid = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("reset_rx", wireless_rx, 1'b1);
        chk("reset_set", wireless_set, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", cfg_done, 1'b0);
        chk("reset_ready", data_ready, 1'b1);
        m_free_at = cyc;
        @(negedge clk);
        rst_n = 1'b1;

        // Latency table: each entry runs alone from idle.
        for (int v = 0; v < 6; v++) begin
            cfg_start  = vecs[v].is_cfg;
            cfg_cmd    = vecs[v].cmd;
            data_valid = ~vecs[v].is_cfg;
            data_in    = vecs[v].data;
            step();
            t0 = s_cyc;
            cfg_start  = 1'b0;
            data_valid = 1'b0;
            run_to_idle(rdy_c, done_c, ndone);
            chk_int("table_ready_lat", rdy_c - t0, vecs[v].ready_lat);
            if (vecs[v].is_cfg) begin
                chk_int("table_done_lat", done_c - t0, vecs[v].done_lat);
                chk_int("table_done_count", ndone, 1);
            end
        end

        // Back-to-back raw bytes with data_valid held.
        data_valid = 1'b1; data_in = 8'h00;
        step();
        t0 = s_cyc;
        data_in = 8'hFF;
        run_to_idle(rdy_c, done_c, ndone);
        chk_int("b2b_first_ready", rdy_c - t0, 101);
        data_valid = 1'b0;
        run_to_idle(rdy_c, done_c, ndone);
        chk_int("b2b_second_ready", rdy_c - t0, 202);

        // cfg_start beats data_valid in the same cycle.
        cfg_start = 1'b1; data_valid = 1'b1; cfg_cmd = 2'd0; data_in = 8'h5A;
        step();
        t0 = s_cyc;
        chk("prio_ready", s_ready, 1'b0);
        cfg_start = 1'b0; data_valid = 1'b0;
        run_to_idle(rdy_c, done_c, ndone);
        chk_int("prio_done_count", ndone, 1);
        chk_int("prio_ready_lat", rdy_c - t0, 210);

        // A second cfg_start mid-sequence is ignored.
        cfg_start = 1'b1; cfg_cmd = 2'd1;
        step();
        t0 = s_cyc;
        cfg_start = 1'b0;
        repeat (50) step();
        cfg_start = 1'b1; cfg_cmd = 2'd2; data_valid = 1'b1;
        step();
        chk("ignore_ready", s_ready, 1'b0);
        cfg_start = 1'b0; data_valid = 1'b0;
        run_to_idle(rdy_c, done_c, ndone);
        chk_int("ignore_done_count", ndone, 1);
        chk_int("ignore_ready_lat", rdy_c - t0, 710);

        // Reset during the 4th data bit of a raw frame.
        data_valid = 1'b1; data_in = 8'h3C;
        step();
        t0 = s_cyc;
        data_valid = 1'b0;
        while (cyc < t0 + 1 + 4*DIV + 3) step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1; data_valid = 1'b1; data_in = 8'h81;
        step();
        t_rst = s_cyc;
        chk("rst_rx", s_rx, 1'b1);
        chk("rst_set", s_set, 1'b1);
        chk("rst_busy", s_busy, 1'b0);
        chk("rst_ready", s_ready, 1'b1);
        data_valid = 1'b0;
        step();
        chk("rst_accept_busy", s_busy, 1'b1);
        run_to_idle(rdy_c, done_c, ndone);
        chk_int("rst_new_ready_lat", rdy_c - t_rst, 101);

        // Randomized traffic against the schedule model.
        for (int i = 0; i < 6000; i++) begin
            rst_n      = ($urandom_range(0, 999) != 0);
            cfg_start  = ($urandom_range(0, 59) == 0);
            cfg_cmd    = 2'($urandom);
            data_valid = ($urandom_range(0, 2) == 0);
            data_in    = 8'($urandom);
            step();
        end
        rst_n = 1'b1; cfg_start = 1'b0; data_valid = 1'b0;
        run_to_idle(rdy_c, done_c, ndone);
        chk("final_idle", s_ready, 1'b1);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
